// File: rtl/sub_eight_serial_if.sv
// Handshake and data bundle between the ALU control FSM and the bit-serial subtractor.
interface sub_eight_serial_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] dIn0;
  logic [WIDTH-1:0] dIn1;
  logic             enable;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dOut;
  logic             bOut;
  logic             zero;

  modport master (
    output start, dIn0, dIn1, enable,
    input  busy, done, dOut, bOut, zero
  );

  modport slave (
    input  start, dIn0, dIn1, enable,
    output busy, done, dOut, bOut, zero
  );
endinterface

// File: rtl/sub_eight_serial.sv
// Bit-serial subtractor: one full-subtractor cell processes dIn0 - dIn1 LSB first,
// one bit per clock, then latches difference, borrow and zero flags.
module sub_eight_serial #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstN,
  sub_eight_serial_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    bitCount;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] partial;
  logic             borrowFf;
  logic [WIDTH-1:0] resultReg;
  logic             borrowReg;
  logic             zeroReg;
  logic             busyReg;
  logic             doneReg;

  logic             diffBit;
  logic             nextBorrow;
  logic [WIDTH-1:0] nextPartial;

  // Single full-subtractor cell fed from the LSBs of the operand shift registers.
  always_comb begin
    diffBit     = regA[0] ^ regB[0] ^ borrowFf;
    nextBorrow  = (~regA[0] & regB[0]) | (~(regA[0] ^ regB[0]) & borrowFf);
    nextPartial = {diffBit, partial[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state     <= IDLE;
      bitCount  <= '0;
      regA      <= '0;
      regB      <= '0;
      partial   <= '0;
      borrowFf  <= 1'b0;
      resultReg <= '0;
      borrowReg <= 1'b0;
      zeroReg   <= 1'b0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.start) begin
            regA     <= bus.dIn0;
            regB     <= bus.dIn1;
            borrowFf <= 1'b0;
            bitCount <= '0;
            busyReg  <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          regA     <= regA >> 1;
          regB     <= regB >> 1;
          partial  <= nextPartial;
          borrowFf <= nextBorrow;
          bitCount <= bitCount + CW'(1);
          // Result registers only move here, so outputs hold the old result while busy.
          if (bitCount == LAST_BIT) begin
            state     <= DONE;
            busyReg   <= 1'b0;
            doneReg   <= 1'b1;
            resultReg <= nextPartial;
            borrowReg <= nextBorrow;
            zeroReg   <= (nextPartial == '0);
          end
        end
        DONE: begin
          doneReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busyReg <= 1'b0;
          doneReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.dOut = bus.enable ? resultReg : '0;
  assign bus.bOut = bus.enable & borrowReg;
  assign bus.zero = bus.enable & zeroReg;

endmodule

// File: tb/tb_sub_eight_serial.sv
// Self-checking bench for sub_eight_serial: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_sub_eight_serial;

  logic clk;
  logic rstN;
  int   checks   = 0;
  int   failures = 0;
  bit   checkOn  = 0;

  sub_eight_serial_if #(.WIDTH(8)) bus ();

  sub_eight_serial #(.WIDTH(8)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: an accepted request completes eight edges later with plain modular subtraction.
  int       mBusyLeft = 0;
  bit       mDone     = 0;
  bit [7:0] mA        = 0;
  bit [7:0] mB        = 0;
  bit [7:0] mResult   = 0;
  bit       mBorrow   = 0;
  bit       mZero     = 0;

  always @(posedge clk) begin
    if (rstN !== 1'b1) begin
      mBusyLeft = 0;
      mDone     = 0;
      mResult   = 0;
      mBorrow   = 0;
      mZero     = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (mBusyLeft > 0) begin
      mBusyLeft--;
      if (mBusyLeft == 0) begin
        mDone   = 1;
        mResult = mA - mB;
        mBorrow = (mA < mB);
        mZero   = (mResult == 8'h00);
      end
    end else if (bus.start === 1'b1) begin
      mBusyLeft = 8;
      mA        = bus.dIn0;
      mB        = bus.dIn1;
    end
    #2;
    if (checkOn) begin
      checkOutput("cyc_busy", 32'(bus.busy), 32'(mBusyLeft > 0));
      checkOutput("cyc_done", 32'(bus.done), 32'(mDone));
      checkOutput("cyc_dOut", 32'(bus.dOut), bus.enable ? 32'(mResult) : 32'h0);
      checkOutput("cyc_bOut", 32'(bus.bOut), bus.enable ? 32'(mBorrow) : 32'h0);
      checkOutput("cyc_zero", 32'(bus.zero), bus.enable ? 32'(mZero) : 32'h0);
    end
  end

  // Issues one request from idle; reports the cycle in which done appears and how many cycles busy was high.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int doneCycle, output int busyCycles);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.dIn0  = a;
    bus.dIn1  = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.dIn0   = 8'($urandom);
    bus.dIn1   = 8'($urandom);
    doneCycle  = 1;
    busyCycles = int'(bus.busy);
    while (bus.done !== 1'b1 && doneCycle < 20) begin
      @(posedge clk);
      #1;
      doneCycle++;
      busyCycles += int'(bus.busy);
    end
  endtask

  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] expD, input logic expB, input logic expZ);
    int dc, bc;
    applyStimulus(a, b, dc, bc);
    checkOutput({tag, "_latency"}, 32'(dc), 32'd9);
    checkOutput({tag, "_busyCycles"}, 32'(bc), 32'd8);
    checkOutput({tag, "_dOut"}, 32'(bus.dOut), 32'(expD));
    checkOutput({tag, "_bOut"}, 32'(bus.bOut), 32'(expB));
    checkOutput({tag, "_zero"}, 32'(bus.zero), 32'(expZ));
  endtask

  initial begin
    int doneCount;
    int waitCycles;

    bus.start  = 1'b0;
    bus.dIn0   = 8'h00;
    bus.dIn1   = 8'h00;
    bus.enable = 1'b1;
    rstN       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOn = 1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_dOut", 32'(bus.dOut), 32'h00);
    checkOutput("reset_bOut", 32'(bus.bOut), 32'd0);
    checkOutput("reset_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    runOp("op50m20", 8'h50, 8'h20, 8'h30, 1'b0, 1'b0);
    runOp("op00m01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    runOp("op37m37", 8'h37, 8'h37, 8'h00, 1'b0, 1'b1);
    runOp("op80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

    @(negedge clk);
    bus.enable = 1'b0;
    #1;
    checkOutput("gate_dOut", 32'(bus.dOut), 32'h00);
    checkOutput("gate_bOut", 32'(bus.bOut), 32'd0);
    checkOutput("gate_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    bus.enable = 1'b1;
    #1;
    checkOutput("ungate_dOut", 32'(bus.dOut), 32'h7F);

    // Start pulses during SHIFT and during DONE must both be dropped.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.dIn0  = 8'h10;
    bus.dIn1  = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.dIn0  = 8'hAA;
    bus.dIn1  = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    doneCount  = 0;
    waitCycles = 0;
    while (bus.done !== 1'b1 && waitCycles < 20) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    doneCount += int'(bus.done === 1'b1);
    checkOutput("ignore_dOut", 32'(bus.dOut), 32'h0F);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dIn0  = 8'hAA;
    bus.dIn1  = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      doneCount += int'(bus.done === 1'b1);
    end
    checkOutput("ignore_doneCount", 32'(doneCount), 32'd1);
    checkOutput("ignore_idleBusy", 32'(bus.busy), 32'd0);
    checkOutput("ignore_dOutHeld", 32'(bus.dOut), 32'h0F);

    // Reset lands on the edge that closes the fourth SHIFT cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.dIn0  = 8'hF0;
    bus.dIn1  = 8'h0F;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_dOut", 32'(bus.dOut), 32'h00);
    @(negedge clk);
    rstN = 1'b1;
    doneCount = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      doneCount += int'(bus.done === 1'b1);
    end
    checkOutput("abort_noDone", 32'(doneCount), 32'd0);
    runOp("op05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    // Random traffic, including spurious starts, enable toggling and occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rstN       = ($urandom_range(0, 80) != 0);
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.dIn0   = 8'($urandom);
      bus.dIn1   = 8'($urandom);
      bus.enable = ($urandom_range(0, 5) != 0);
    end
    @(negedge clk);
    rstN       = 1'b1;
    bus.start  = 1'b0;
    bus.enable = 1'b1;
    repeat (12) @(posedge clk);
    #3;
    checkOn = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub_eight_serial.md
Name: sub_eight_serial

Overview:
- Multi-cycle, bit-serial 8-bit subtractor for the hiddenCPU datapath; the inverse operation to the ripple adder.
- Computes dIn0 - dIn1 (mod 256) one bit per clock, LSB first, and reports borrow and zero flags.
- Trades latency for area: one full-subtractor cell plus shift registers replace an 8-cell ripple chain.
- Used by the ALU for SUB/CMP, with a start/busy/done handshake towards the control FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (only 8 is required and verified).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstN  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- dIn0  input  8  minuend; captured on the accepted start.
- dIn1  input  8  subtrahend; captured on the accepted start.
- enable  input  1  output gate; when low, dOut, bOut and zero read 0. Internal state is unaffected.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  one-cycle pulse when the result registers update.
- dOut  output  8  last completed difference, gated by enable.
- bOut  output  1  last completed borrow, gated by enable; 1 iff dIn0 < dIn1 unsigned.
- zero  output  1  1 iff the last completed difference is 0x00, gated by enable.

Behaviour:
- Reset (rstN=0 at a clock edge):
  - state=IDLE, bit counter=0, operand shift registers=0, borrow flop=0.
  - Result register=0x00, borrow result=0, zero result=0; busy=0, done=0.
  - Reset mid-operation aborts: no done pulse, result registers cleared, start ignored while rstN=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch dIn0 into register A and dIn1 into register B, clear the borrow flop and counter, go to SHIFT.
- SHIFT (busy=1), at each edge:
  - a=A[0], b=B[0], br=borrow flop.
  - diff = a^b^br.
  - br' = (~a&b) | (~(a^b)&br).
  - A and B shift right by 1; diff shifts into the MSB of the partial-result register; the counter increments.
  - After the 8th bit (counter reaching 7 at that edge), go to DONE and copy the partial result, br' and (partial==0) into the result, borrow and zero registers.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0; then return to IDLE.
  - start in the DONE cycle is ignored.
- Latency:
  - start sampled at edge k; bits are processed on edges k+1..k+8.
  - done is high in the cycle following edge k+8.
  - The next start is accepted at edge k+10 at the earliest.
- Handshake rules:
  - start while busy or done is ignored and not queued.
  - Operand inputs may change freely after the accepting edge.
- Results:
  - dOut, bOut and zero hold the previous result throughout SHIFT and change only on entry to DONE.
  - enable gating is combinational on these registered values; toggling enable never alters the stored result.
- Arithmetic: unsigned modulo 2^8, so dOut = (dIn0 - dIn1) & 0xFF and bOut = (dIn0 < dIn1).

Test Plan:
- Reset, enable=1, no start -> busy=0, done=0, dOut=0x00, bOut=0, zero=0.
- start with 0x50, 0x20 -> done high exactly 9 cycles after start is sampled; dOut=0x30, bOut=0, zero=0; busy high for 8 cycles.
- start with 0x00, 0x01 -> dOut=0xFF, bOut=1, zero=0. Then start with 0x37, 0x37 -> dOut=0x00, bOut=0, zero=1.
- Complete 0x80-0x01 (dOut=0x7F), then drop enable -> dOut=0, bOut=0, zero=0. Raise enable again -> dOut=0x7F restored.
- While busy computing 0x10-0x01, pulse start with 0xAA, 0x55 and also assert start in the DONE cycle -> result is 0x0F, exactly one done pulse, FSM back in IDLE.
- Start 0xF0-0x0F, assert rstN=0 on the 4th SHIFT cycle -> next cycle busy=0, dOut=0x00, no done pulse. A following 0x05-0x03 yields 0x02.
